// File: rtl/cnn_mac_pipe.sv
// cnn_mac_pipe: pipelined signed MAC; sums every KLEN feature*weight products,
//   scales by >>> SHIFT and presents the result on a valid/ready output.
// Latency: last pair accepted -> out_valid is MUL_STAGES+1 cycles (operand reg + MUL_STAGES product regs).
// Backpressure: out_valid & ~out_ready freezes the whole pipe and drops in_ready combinationally.
// Build option: define CNN_MAC_SAT_EN to clamp dout to the signed OUT_WIDTH range and flag it on sat;
//   without it dout is the low OUT_WIDTH bits of the shifted sum and sat stays 0.
// ACC_WIDTH must be >= A_WIDTH+B_WIDTH+clog2(KLEN) and > OUT_WIDTH; KLEN and MUL_STAGES must be >= 1.

module cnn_mac_pipe #(
  parameter int A_WIDTH    = 14,
  parameter int B_WIDTH    = 9,
  parameter int ACC_WIDTH  = 32,
  parameter int OUT_WIDTH  = 16,
  parameter int KLEN       = 9,
  parameter int MUL_STAGES = 2,
  parameter int SHIFT      = 8
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [A_WIDTH-1:0]   din0,
  input  logic signed [B_WIDTH-1:0]   din1,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic        [OUT_WIDTH-1:0] dout,
  output logic                        sat
);

  localparam int P_WIDTH = A_WIDTH + B_WIDTH;
  localparam int CNT_W   = (KLEN > 1) ? $clog2(KLEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(KLEN - 1);

  // Flow control
  logic w_stall;
  logic w_accept;

  // Operand register (feeds the multiplier)
  logic                      r_in_vld;
  logic signed [A_WIDTH-1:0] r_a;
  logic signed [B_WIDTH-1:0] r_b;
  logic signed [P_WIDTH-1:0] w_mul;

  // Product pipe
  logic [MUL_STAGES-1:0]     r_pvld;
  logic signed [P_WIDTH-1:0] r_prod [MUL_STAGES];

  // Accumulator and tap counter
  logic                        w_take;
  logic                        w_last;
  logic signed [ACC_WIDTH-1:0] w_prod_ext;
  logic signed [ACC_WIDTH-1:0] w_sum;
  logic signed [ACC_WIDTH-1:0] w_shift;
  logic signed [ACC_WIDTH-1:0] r_acc;
  logic        [CNT_W-1:0]     r_cnt;

  // Output stage
  logic [OUT_WIDTH-1:0] w_dout_nxt;
  logic                 w_sat_nxt;
  logic [OUT_WIDTH-1:0] r_dout;
  logic                 r_out_vld;
  logic                 r_sat;

  // A held result freezes everything upstream, so no pair can be taken either.
  assign w_stall  = r_out_vld & ~out_ready;
  assign in_ready = ~w_stall;
  assign w_accept = in_valid & ~w_stall;

  // Full-precision signed product; both operands sign-extended to the product width.
  assign w_mul = P_WIDTH'(r_a) * P_WIDTH'(r_b);

  // Capture the accepted pair; a cycle without an accept inserts a bubble.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_in_vld <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
    end else if (!w_stall) begin
      r_in_vld <= w_accept;
      if (w_accept) begin
        r_a <= din0;
        r_b <= din1;
      end
    end
  end

  // Product shift register; valid bits travel with the data so bubbles never accumulate.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_pvld <= '0;
      for (int s = 0; s < MUL_STAGES; s++) begin
        r_prod[s] <= '0;
      end
    end else if (!w_stall) begin
      r_pvld[0] <= r_in_vld;
      r_prod[0] <= w_mul;
      for (int s = 1; s < MUL_STAGES; s++) begin
        r_pvld[s] <= r_pvld[s-1];
        r_prod[s] <= r_prod[s-1];
      end
    end
  end

  // Tap 0 restarts the sum from the product itself, so back-to-back groups need no clear cycle.
  assign w_take     = r_pvld[MUL_STAGES-1] & ~w_stall;
  assign w_last     = (r_cnt == CNT_LAST);
  assign w_prod_ext = ACC_WIDTH'(r_prod[MUL_STAGES-1]);
  assign w_sum      = (r_cnt == '0) ? w_prod_ext : (r_acc + w_prod_ext);
  assign w_shift    = w_sum >>> SHIFT;

`ifdef CNN_MAC_SAT_EN
  // The shifted sum fits OUT_WIDTH only if all bits from OUT_WIDTH-1 upward agree.
  logic [ACC_WIDTH-OUT_WIDTH:0] w_hi;
  logic                         w_ovf;

  assign w_hi  = w_shift[ACC_WIDTH-1:OUT_WIDTH-1];
  assign w_ovf = ~((&w_hi) | ~(|w_hi));

  // Clamp toward the sign of the true sum.
  always_comb begin
    w_dout_nxt = w_shift[OUT_WIDTH-1:0];
    w_sat_nxt  = 1'b0;
    if (w_ovf) begin
      w_sat_nxt  = 1'b1;
      w_dout_nxt = w_hi[ACC_WIDTH-OUT_WIDTH] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                             : {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end
  end
`else
  // Wrap: keep the low bits; the rest of the shifted sum is intentionally dropped.
  logic w_unused_hi;

  assign w_unused_hi = ^w_shift[ACC_WIDTH-1:OUT_WIDTH];
  assign w_dout_nxt  = w_shift[OUT_WIDTH-1:0];
  assign w_sat_nxt   = 1'b0;
`endif

  // Accumulate each valid product leaving the pipe and advance the tap counter.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_take) begin
      r_acc <= w_sum;
      r_cnt <= w_last ? '0 : (r_cnt + CNT_W'(1));
    end
  end

  // Register the scaled result on the last tap; dout/sat only change when a new result lands.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_out_vld <= 1'b0;
      r_dout    <= '0;
      r_sat     <= 1'b0;
    end else begin
      r_out_vld <= (w_take & w_last) | (r_out_vld & ~out_ready);
      if (w_take && w_last) begin
        r_dout <= w_dout_nxt;
        r_sat  <= w_sat_nxt;
      end
    end
  end

  assign out_valid = r_out_vld;
  assign dout      = r_dout;
  assign sat       = r_sat;

endmodule

// File: tb/tb_cnn_mac_pipe.sv
// Bench for cnn_mac_pipe: directed and random pairs against an arithmetic reference
// (group sum -> wrap to 32 bits -> >>> 8 -> wrap or clamp to 16 bits), plus a KLEN=1 instance.

module tb_cnn_mac_pipe;

  localparam int KLEN = 9;

  logic               ap_clk;
  logic               ap_rst_n;

  logic               in_valid, in_ready, out_valid, out_ready, sat;
  logic signed [13:0] din0;
  logic signed [8:0]  din1;
  logic [15:0]        dout;

  logic               in_valid1, in_ready1, out_valid1, out_ready1, sat1;
  logic signed [13:0] din0_1;
  logic signed [8:0]  din1_1;
  logic [15:0]        dout1;

  int          n_checks, n_fail;
  int          cyc, last_acc_cyc, n_acc, vld_cycles, stall_cycles;
  longint      m_sum;
  int          m_cnt;
  logic [15:0] exp_d[$];
  logic        exp_s[$];
  logic [15:0] obs_d[$];
  logic        obs_s[$];
  int          obs_cyc[$];

  cnn_mac_pipe u_dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din0      (din0),
    .din1      (din1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .sat       (sat)
  );

  cnn_mac_pipe #(.KLEN(1), .MUL_STAGES(1)) u_dut1 (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .din0      (din0_1),
    .din1      (din1_1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .dout      (dout1),
    .sat       (sat1)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: sum KLEN products, wrap to 32 bits, floor-shift by 8, then wrap or clamp to 16 bits.
  task automatic model_accept(input logic signed [13:0] a, input logic signed [8:0] b);
    int          s, sh;
    logic [15:0] d;
    logic        st;
    m_sum += longint'(a) * longint'(b);
    m_cnt++;
    if (m_cnt == KLEN) begin
      s  = int'(m_sum);
      sh = s >>> 8;
      d  = sh[15:0];
      st = 1'b0;
`ifdef CNN_MAC_SAT_EN
      if (sh > 32767) begin
        d = 16'h7FFF; st = 1'b1;
      end else if (sh < -32768) begin
        d = 16'h8000; st = 1'b1;
      end
`endif
      exp_d.push_back(d);
      exp_s.push_back(st);
      m_sum = 0;
      m_cnt = 0;
    end
  endtask

  // Drive one cycle's inputs (caller is at a falling edge) and log the handshakes the next rising edge will see.
  task automatic drive_sample(input bit iv, input logic signed [13:0] a, input logic signed [8:0] b,
                              input bit ordy);
    in_valid  = iv;
    din0      = a;
    din1      = b;
    out_ready = ordy;
    #1;
    cyc++;
    if (in_valid && in_ready) begin
      model_accept(a, b);
      last_acc_cyc = cyc;
      n_acc++;
    end
    if (out_valid) vld_cycles++;
    if (out_valid && !out_ready) begin
      stall_cycles++;
      check("stall_in_ready", 32'(in_ready), 32'd0);
      if (exp_d.size() > obs_d.size())
        check("stall_dout_held", 32'(dout), 32'(exp_d[obs_d.size()]));
      else
        check("stall_without_expected_result", 32'(exp_d.size()), 32'(obs_d.size() + 1));
    end
    if (out_valid && out_ready) begin
      obs_d.push_back(dout);
      obs_s.push_back(sat);
      obs_cyc.push_back(cyc);
    end
  endtask

  task automatic cycle(input bit iv, input logic signed [13:0] a, input logic signed [8:0] b,
                       input bit ordy);
    @(negedge ap_clk);
    drive_sample(iv, a, b, ordy);
  endtask

  task automatic clear_logs();
    exp_d.delete(); exp_s.delete();
    obs_d.delete(); obs_s.delete(); obs_cyc.delete();
    vld_cycles   = 0;
    stall_cycles = 0;
  endtask

  task automatic compare_results(input string tag);
    int n;
    check({tag, "_count"}, 32'(obs_d.size()), 32'(exp_d.size()));
    n = (obs_d.size() < exp_d.size()) ? obs_d.size() : exp_d.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_dout"}, 32'(obs_d[i]), 32'(exp_d[i]));
      check({tag, "_sat"},  32'(obs_s[i]), 32'(exp_s[i]));
    end
  endtask

  initial begin
    int          start, stall_left;
    bit          stall_done, ordy, iv;
    logic [15:0] d1_obs[$];
    int          d1_cyc[$];

    n_checks = 0; n_fail = 0; cyc = 0; last_acc_cyc = 0; n_acc = 0;
    m_sum = 0; m_cnt = 0;
    clear_logs();
    in_valid  = 1'b0; din0   = '0; din1   = '0; out_ready  = 1'b1;
    in_valid1 = 1'b0; din0_1 = '0; din1_1 = '0; out_ready1 = 1'b1;
    ap_rst_n  = 1'b0;

    // Reset state
    repeat (3) @(negedge ap_clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_sat", 32'(sat), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid1", 32'(out_valid1), 32'd0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;

    // 100*50 x9 = 45000 -> 175; one-cycle pulse three cycles after the last accept
    clear_logs();
    for (int i = 0; i < 9; i++) cycle(1'b1, 14'sd100, 9'sd50, 1'b1);
    repeat (8) cycle(1'b0, '0, '0, 1'b1);
    compare_results("t1");
    if (obs_d.size() > 0) begin
      check("t1_dout_const", 32'(obs_d[0]), 32'h00AF);
      check("t1_latency", 32'(obs_cyc[0] - last_acc_cyc - 1), 32'd3);
    end
    check("t1_pulse_width", 32'(vld_cycles), 32'd1);

    // -45000 -> floor(-175.8) = -176
    clear_logs();
    for (int i = 0; i < 9; i++) cycle(1'b1, -14'sd100, 9'sd50, 1'b1);
    repeat (8) cycle(1'b0, '0, '0, 1'b1);
    compare_results("t2");
    if (obs_d.size() > 0) begin
      check("t2_dout_const", 32'(obs_d[0]), 32'h0000FF50);
      check("t2_sat_const", 32'(obs_s[0]), 32'd0);
    end

    // 18874368 >>> 8 = 73728: out of 16-bit range
    clear_logs();
    for (int i = 0; i < 9; i++) cycle(1'b1, -14'sd8192, -9'sd256, 1'b1);
    repeat (8) cycle(1'b0, '0, '0, 1'b1);
    compare_results("t3");
    if (obs_d.size() > 0) begin
`ifdef CNN_MAC_SAT_EN
      check("t3_dout_const", 32'(obs_d[0]), 32'h7FFF);
      check("t3_sat_const", 32'(obs_s[0]), 32'd1);
`else
      check("t3_dout_const", 32'(obs_d[0]), 32'h2000);
      check("t3_sat_const", 32'(obs_s[0]), 32'd0);
`endif
    end

    // 27 random pairs, sparse in_valid, first result held for 5 cycles
    clear_logs();
    start      = n_acc;
    stall_left = 0;
    stall_done = 1'b0;
    for (int k = 0; k < 800 && ((n_acc - start) < 27 || obs_d.size() < 3); k++) begin
      @(negedge ap_clk);
      ordy = 1'b1;
      if (stall_left > 0) begin
        ordy = 1'b0;
        stall_left--;
      end else if (!stall_done && out_valid) begin
        ordy       = 1'b0;
        stall_left = 4;
        stall_done = 1'b1;
      end
      iv = ((n_acc - start) < 27) ? 1'($urandom_range(0, 1)) : 1'b0;
      drive_sample(iv, 14'($urandom()), 9'($urandom()), ordy);
    end
    repeat (4) cycle(1'b0, '0, '0, 1'b1);
    check("t4_accepted", 32'(n_acc - start), 32'd27);
    check("t4_stall_cycles", 32'(stall_cycles), 32'd5);
    compare_results("t4");

    // Reset after 4 taps discards them; the next group starts at tap 0
    clear_logs();
    for (int i = 0; i < 4; i++) cycle(1'b1, 14'($urandom()), 9'($urandom()), 1'b1);
    @(negedge ap_clk);
    ap_rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check("t5_rst_out_valid", 32'(out_valid), 32'd0);
    check("t5_rst_dout", 32'(dout), 32'd0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    m_sum = 0;
    m_cnt = 0;
    // A +256 weight does not fit 9 signed bits; (-1)*(-256) gives the same +256 product.
    for (int i = 0; i < 9; i++) cycle(1'b1, -14'sd1, -9'sd256, 1'b1);
    repeat (8) cycle(1'b0, '0, '0, 1'b1);
    compare_results("t5");
    if (obs_d.size() > 0) check("t5_dout_const", 32'(obs_d[0]), 32'd9);

    // KLEN=1, MUL_STAGES=1: (-i)*(-256) >>> 8 = i, latency 2, one result per cycle
    for (int i = 0; i < 14; i++) begin
      @(negedge ap_clk);
      in_valid1 = (i < 8);
      din0_1    = -14'(i);
      din1_1    = -9'sd256;
      #1;
      if (out_valid1) begin
        d1_obs.push_back(dout1);
        d1_cyc.push_back(i);
      end
    end
    in_valid1 = 1'b0;
    check("t6_in_ready", 32'(in_ready1), 32'd1);
    check("t6_sat", 32'(sat1), 32'd0);
    check("t6_count", 32'(d1_obs.size()), 32'd8);
    for (int j = 0; j < d1_obs.size() && j < 8; j++) begin
      check("t6_dout", 32'(d1_obs[j]), 32'(j));
      check("t6_cycle", 32'(d1_cyc[j]), 32'(j + 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cnn_mac_pipe.md
Name: cnn_mac_pipe

Overview:
- Pipelined signed multiply-accumulate for the conv layers.
- Accepts a stream of (feature, weight) pairs and sums every KLEN products into one accumulator result.
- Scales the result by an arithmetic right shift and emits it on a valid/ready output.
- Parametrised, handshaked replacement for the fixed-width combinational 14s x 9s multiplier cores; sits between the window buffer and the activation/output stage.

Parameters:
- A_WIDTH, 14: signed width of din0 (feature).
- B_WIDTH, 9: signed width of din1 (weight).
- ACC_WIDTH, 32: accumulator width; must be >= A_WIDTH+B_WIDTH+clog2(KLEN).
- OUT_WIDTH, 16: width of dout.
- KLEN, 9: products per output (3x3 kernel); must be >= 1.
- MUL_STAGES, 2: register stages in the multiplier pipe; must be >= 1.
- SHIFT, 8: arithmetic right shift applied to the final sum before output.

Ports:
- ap_clk  in  1  clock; all logic on rising edge.
- ap_rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  din0/din1 pair valid.
- in_ready  out  1  block can accept a pair.
- din0  in  A_WIDTH  signed feature.
- din1  in  B_WIDTH  signed weight.
- out_valid  out  1  dout valid.
- out_ready  in  1  consumer accepts dout.
- dout  out  OUT_WIDTH  scaled result.
- sat  out  1  dout was clamped (see Optional Feature).

Behaviour:
- Reset (ap_rst_n low, asynchronous): all pipe valid bits, product registers, accumulator, tap counter, dout, out_valid and sat are 0. Reset asserted mid-sum discards the partial sum; the next accepted pair is tap 0.
- Stall:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall (combinational).
  - While stall is high, all pipe registers, the accumulator and the counter hold.
- Accept: a pair is taken on a rising edge with in_valid & in_ready. Product = signed(din0)*signed(din1), A_WIDTH+B_WIDTH bits, full precision.
- Multiplier pipe: MUL_STAGES registers, each with a valid bit; bubbles propagate and are never accumulated.
- Accumulate (when a valid product leaves the pipe and not stalled):
  - Product is sign-extended to ACC_WIDTH.
  - acc = (cnt==0) ? prod : acc+prod.
  - Overflow wraps modulo 2^ACC_WIDTH.
  - cnt increments and wraps to 0 after KLEN-1.
- Output: on the product with cnt==KLEN-1, the registered dout takes (acc+prod) >>> SHIFT (floor rounding), reduced to OUT_WIDTH, and out_valid is set.
- Latency: out_valid rises MUL_STAGES+1 cycles after the edge that accepted the last pair of a group.
- Throughput: one pair per cycle when unstalled. Back-to-back groups are supported: tap 0 of the next group may accumulate in the same cycle the previous result is registered.
- out_valid clears on the edge where out_ready is high, unless a new result is registered in that same edge; in that case it stays 1 and dout/sat update.
- dout and sat are stable while out_valid & ~out_ready.

Optional Feature:
- Macro: CNN_MAC_SAT_EN.
- Defined: the shifted sum is clamped to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]. sat is 1 with the result if clamping occurred, else 0.
- Undefined: the low OUT_WIDTH bits of the shifted sum are taken (wrap), and sat is tied to 0.

Test Plan (all with default parameters unless noted):
- 9 pairs a=100, b=50 back-to-back, out_ready=1 -> sum 45000; dout=175; out_valid pulses 1 cycle, 3 cycles after the 9th accept.
- 9 pairs a=-100, b=50 -> sum -45000; dout=-176 (floor); sat=0.
- 9 pairs a=-8192, b=-256 -> sum 18874368, shifted 73728:
  - with CNN_MAC_SAT_EN: dout=32767, sat=1.
  - without: dout=8192, sat=0.
- 27 pairs with in_valid toggling randomly and out_ready held low for 5 cycles after the first result:
  - in_ready=0 during the stall; no pair lost.
  - 3 results in order, each equal to the reference sum>>>8.
- Reset pulse after the 4th pair of a group, then 9 pairs a=1, b=256 -> dout=9; the first 4 pairs do not contribute.
- KLEN=1, MUL_STAGES=1: stream a=i, b=256 for i=0..7 -> dout=i each cycle, latency 2, full throughput with out_ready=1.
